// File: rtl/udt_pkg.sv
// Shared definitions for the UDT transmit path: stream widths, control port
// indices, grant identifier width and the arbiter FSM encoding.
package udt_pkg;

    localparam int AXIS_DW = 64;
    localparam int AXIS_KW = 8;
    localparam int GRANT_W = 3;

    localparam int CTRL_ACK       = 0;
    localparam int CTRL_ACK2      = 1;
    localparam int CTRL_NAK       = 2;
    localparam int CTRL_KEEPALIVE = 3;
    localparam int CTRL_HANDSHAKE = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } tx_state_t;

endpackage

// File: rtl/udt_rr_arbiter.sv
// Rotating-priority encoder: picks the first asserted request at or after ptr,
// wrapping around, and reports it both one-hot and as an index.
module udt_rr_arbiter
    import udt_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0]       req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [N-1:0]       gnt,
    output logic [GRANT_W-1:0] gnt_idx,
    output logic               gnt_valid
);

    // scan from ptr upward; the first hit latches and later hits are masked
    always_comb begin
        int  idx_s;
        logic take_s;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx_s     = 0;
        take_s    = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s      = (int'(ptr) + k) % N;
            take_s     = req[idx_s] && !gnt_valid;
            gnt[idx_s] = take_s;
            gnt_idx    = take_s ? GRANT_W'(idx_s) : gnt_idx;
            gnt_valid  = gnt_valid | take_s;
        end
    end

endmodule

// File: rtl/udt_tx_arbiter.sv
// Packet-granular scheduler merging UDT control and data packet streams onto
// the single UDP TX AXI-Stream path; control wins unless data has waited too long.
module udt_tx_arbiter
    import udt_pkg::*;
#(
    parameter int NUM_CTRL       = 5,
    parameter int MAX_CTRL_BURST = 4,
    parameter int CNT_W          = 32
) (
    input  logic                        core_clk,
    input  logic                        core_rst,
    input  logic                        tx_enable,
    input  logic [NUM_CTRL*AXIS_DW-1:0] ctrl_tdata,
    input  logic [NUM_CTRL*AXIS_KW-1:0] ctrl_tkeep,
    input  logic [NUM_CTRL-1:0]         ctrl_tvalid,
    input  logic [NUM_CTRL-1:0]         ctrl_tlast,
    output logic [NUM_CTRL-1:0]         ctrl_tready,
    input  logic [AXIS_DW-1:0]          data_tdata,
    input  logic [AXIS_KW-1:0]          data_tkeep,
    input  logic                        data_tvalid,
    input  logic                        data_tlast,
    output logic                        data_tready,
    output logic [AXIS_DW-1:0]          out_tdata,
    output logic [AXIS_KW-1:0]          out_tkeep,
    output logic                        out_tvalid,
    output logic                        out_tlast,
    input  logic                        out_tready,
    output logic [GRANT_W-1:0]          grant_id,
    output logic                        busy,
    output logic [CNT_W-1:0]            ctrl_pkt_cnt,
    output logic [CNT_W-1:0]            data_pkt_cnt
);

    localparam int                   BURST_W   = $clog2(MAX_CTRL_BURST + 1);
    localparam logic [BURST_W-1:0]   BURST_MAX = BURST_W'(MAX_CTRL_BURST);
    localparam logic [GRANT_W-1:0]   DATA_ID   = GRANT_W'(NUM_CTRL);
    localparam logic [GRANT_W-1:0]   LAST_CTRL = GRANT_W'(NUM_CTRL - 1);

    tx_state_t           state_r, state_nxt_s;
    logic [GRANT_W-1:0]  grant_id_r, rr_ptr_r;
    logic [NUM_CTRL-1:0] ctrl_sel_r;
    logic [BURST_W-1:0]  burst_cnt_r;
    logic [CNT_W-1:0]    ctrl_pkt_cnt_r, data_pkt_cnt_r;

    logic [NUM_CTRL-1:0] ctrl_gnt_s, ctrl_act_s;
    logic [GRANT_W-1:0]  ctrl_idx_s;
    logic                ctrl_any_s, data_act_s, xfer_s;
    logic                force_data_s, pick_data_s, grant_s, last_beat_s;

    udt_rr_arbiter #(.N(NUM_CTRL)) u_rr (
        .req       (ctrl_tvalid),
        .ptr       (rr_ptr_r),
        .gnt       (ctrl_gnt_s),
        .gnt_idx   (ctrl_idx_s),
        .gnt_valid (ctrl_any_s)
    );

    // winner selection: a saturated burst counter forces data ahead of control
    always_comb begin
        xfer_s       = (state_r == ST_XFER);
        force_data_s = data_tvalid && (burst_cnt_r == BURST_MAX);
        pick_data_s  = force_data_s || (!ctrl_any_s && data_tvalid);
        grant_s      = (state_r == ST_IDLE) && tx_enable && (ctrl_any_s || data_tvalid);
        ctrl_act_s   = ctrl_sel_r & {NUM_CTRL{xfer_s}};
        data_act_s   = xfer_s && (grant_id_r == DATA_ID);
    end

    // AND-OR output mux; only the owner of the current packet sees out_tready
    always_comb begin
        out_tdata  = data_tdata & {AXIS_DW{data_act_s}};
        out_tkeep  = data_tkeep & {AXIS_KW{data_act_s}};
        out_tvalid = data_tvalid && data_act_s;
        out_tlast  = data_tlast && data_act_s;
        for (int i = 0; i < NUM_CTRL; i++) begin
            out_tdata  = out_tdata | (ctrl_tdata[i*AXIS_DW +: AXIS_DW] & {AXIS_DW{ctrl_act_s[i]}});
            out_tkeep  = out_tkeep | (ctrl_tkeep[i*AXIS_KW +: AXIS_KW] & {AXIS_KW{ctrl_act_s[i]}});
            out_tvalid = out_tvalid | (ctrl_tvalid[i] & ctrl_act_s[i]);
            out_tlast  = out_tlast | (ctrl_tlast[i] & ctrl_act_s[i]);
        end
        ctrl_tready = ctrl_act_s & {NUM_CTRL{out_tready}};
        data_tready = data_act_s && out_tready;
        last_beat_s = out_tvalid && out_tready && out_tlast;
    end

    // next-state: IDLE always costs one cycle, XFER ends only on the tlast beat
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (last_beat_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // grant owner, round-robin pointer and data-starvation burst counter
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            grant_id_r  <= '0;
            ctrl_sel_r  <= '0;
            rr_ptr_r    <= '0;
            burst_cnt_r <= '0;
        end else if (grant_s && pick_data_s) begin
            grant_id_r  <= DATA_ID;
            ctrl_sel_r  <= '0;
            burst_cnt_r <= '0;
        end else if (grant_s) begin
            grant_id_r  <= ctrl_idx_s;
            ctrl_sel_r  <= ctrl_gnt_s;
            rr_ptr_r    <= (ctrl_idx_s == LAST_CTRL) ? '0 : ctrl_idx_s + GRANT_W'(1);
            burst_cnt_r <= !data_tvalid ? '0 :
                           (burst_cnt_r == BURST_MAX) ? burst_cnt_r : burst_cnt_r + BURST_W'(1);
        end else if ((state_r == ST_IDLE) && !data_tvalid) begin
            burst_cnt_r <= '0;
        end
    end

    // completed-packet counters, wrapping naturally
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            ctrl_pkt_cnt_r <= '0;
            data_pkt_cnt_r <= '0;
        end else if (last_beat_s && data_act_s) begin
            data_pkt_cnt_r <= data_pkt_cnt_r + CNT_W'(1);
        end else if (last_beat_s) begin
            ctrl_pkt_cnt_r <= ctrl_pkt_cnt_r + CNT_W'(1);
        end
    end

    assign grant_id     = grant_id_r;
    assign busy         = (state_r == ST_XFER);
    assign ctrl_pkt_cnt = ctrl_pkt_cnt_r;
    assign data_pkt_cnt = data_pkt_cnt_r;

endmodule
